// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_add cell walks the operands LSB first, one bit per clock,
// under a three-state IDLE/RUN/DONE controller with registered result and status.

module full_add (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;

    full_add u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_c),
        .o_s (w_sum),
        .o_c (w_cout)
    );

    // The newest sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign w_acc_next = {w_sum, r_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= ci;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cout;
                    r_acc <= w_acc_next[WIDTH-1:1];
                    if (r_cnt == LAST) begin
                        // Result only reaches s/co here, so partial sums never show.
                        s       <= w_acc_next;
                        co      <= w_cout;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
